coin_change_dispenser: RTL and testbench
========================================

Name: coin_change_dispenser

Overview:
- Payout end of the coin interface: takes a change amount from the vending controller and ejects it as individual 1/2/5 zł coins into a coin hopper.
- Uses the same one-hot coin encoding as the coin-acceptor input: 001 = 1 zł, 010 = 2 zł, 100 = 5 zł.
- Tracks per-denomination coin inventory and pays out greedily, largest coin first.
- Reports completion, coins paid, and any shortfall when inventory runs out.

Parameters:
- CNT_W, 8, width of the amount, remaining and inventory counters.
- INIT_CNT1, 10, 1 zł coins in inventory after reset.
- INIT_CNT2, 10, 2 zł coins in inventory after reset.
- INIT_CNT5, 10, 5 zł coins in inventory after reset.
- GAP_CYCLES, 2, idle cycles after each acknowledged coin before the next selection (0 allowed).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to pay change_amount.
- change_amount  in  CNT_W  amount in zł, sampled when start is accepted.
- coin_out  out  3  one-hot denomination being ejected; 000 when not ejecting.
- coin_valid  out  1  ejection request to the hopper.
- coin_ack  in  1  hopper has ejected the coin.
- refill_valid  in  1  add one coin to inventory.
- refill_sel  in  3  one-hot denomination of the refill coin.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a payout ends (success or fail).
- error  out  1  one-cycle pulse together with done when the payout is incomplete.
- shortfall  out  CNT_W  amount left unpaid; held until the next accepted start.
- coins_paid  out  CNT_W  coins ejected in the current/last payout.
- cnt1, cnt2, cnt5  out  CNT_W each  current inventory counts.

Behaviour:
- Reset (async) values:
  - state = IDLE; coin_valid = 0; coin_out = 000; busy/done/error = 0.
  - shortfall = 0; coins_paid = 0; remaining = 0.
  - cnt1/cnt2/cnt5 = INIT_CNT1/INIT_CNT2/INIT_CNT5.
- States: IDLE, SELECT, ISSUE, GAP, DONE, FAIL.
- IDLE:
  - On start=1: latch remaining = change_amount; clear coins_paid and shortfall; go to SELECT.
  - start is ignored in every other state.
- SELECT (one cycle), first matching rule wins:
  - remaining == 0 -> DONE.
  - remaining >= 5 and cnt5 > 0 -> ISSUE with 100.
  - remaining >= 2 and cnt2 > 0 -> ISSUE with 010.
  - remaining >= 1 and cnt1 > 0 -> ISSUE with 001.
  - otherwise -> FAIL.
  - Strictly greedy; no backtracking. Example: remaining 3, cnt1 = 0 pays one 2 zł coin, then fails with shortfall 1.
- ISSUE:
  - coin_valid = 1 and coin_out = selected code, both registered.
  - coin_out stays stable until coin_ack is seen high on a clock edge.
  - On that edge: remaining -= denomination; selected inventory counter -= 1; coins_paid += 1; coin_valid = 0.
  - Then go to GAP if GAP_CYCLES > 0, else to SELECT.
  - ISSUE has no timeout; the hopper may stall indefinitely.
- GAP: wait exactly GAP_CYCLES cycles, then go to SELECT.
- DONE: done = 1 for one cycle; shortfall = 0; go to IDLE.
- FAIL: done = 1 and error = 1 for one cycle; shortfall = remaining; go to IDLE.
- Latency:
  - start at edge N -> SELECT in cycle N+1 -> coin_valid high from edge N+2.
  - change_amount = 0 -> done pulse in cycle N+2, no coin ejected.
- Refill:
  - Accepted only in IDLE, with refill_sel one-hot.
  - Increments the selected counter, saturating at 2^CNT_W - 1.
  - Ignored when busy or when refill_sel is not one-hot.
- Start and refill in the same IDLE cycle: both take effect; SELECT sees the refilled count.
- coin_ack outside ISSUE is ignored.
- Arithmetic:
  - remaining never underflows, because selection guarantees denomination <= remaining.
  - coins_paid saturates at its maximum.
- Reset mid-payout:
  - coin_valid drops immediately; an unacknowledged coin is not counted.
  - Inventory returns to the INIT values.

Test Plan:
- Inventory 10/10/10, start with change_amount = 8, ack one cycle after each valid -> coins 100, 010, 001 in order; done with error = 0; coins_paid = 3; cnt5/cnt2/cnt1 = 9/9/9.
- change_amount = 0 -> done pulse 2 cycles after start; coin_valid never asserted; coins_paid = 0.
- cnt1 = 0, change_amount = 3 -> one 010 coin, then done + error; shortfall = 1; cnt2 decremented by 1.
- Hold coin_ack low for 20 cycles during ISSUE -> coin_valid and coin_out stable throughout; no counter changes until ack.
- Refill 001 three times in IDLE, then refill during busy -> cnt1 = INIT_CNT1 + 3; the busy-time refill is ignored; start pulsed while busy is ignored.
- Assert reset while coin_valid = 1 for change_amount = 5 -> coin_valid = 0 immediately; cnt5 = INIT_CNT5; state IDLE; coins_paid = 0.

Source files
------------

// File: rtl/coin_change_dispenser.sv
`timescale 1ns/1ps
// Change payout: pays change_amount as 1/2/5 zl coins, largest first, tracking per-coin inventory.
// Latency: start -> SELECT next cycle -> coin_valid one cycle later; zero amount gives done two cycles after start.
// Backpressure: coin_valid/coin_out hold until coin_ack; the hopper may stall forever, start is ignored while busy.
module coin_change_dispenser #(
    parameter int CNT_W      = 8,
    parameter int INIT_CNT1  = 10,
    parameter int INIT_CNT2  = 10,
    parameter int INIT_CNT5  = 10,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] change_amount,
    output logic [2:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    input  logic             refill_valid,
    input  logic [2:0]       refill_sel,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] shortfall,
    output logic [CNT_W-1:0] coins_paid,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt5
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_t;

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] FIVE     = CNT_W'(5);
    localparam logic [2:0]       COIN1    = 3'b001;
    localparam logic [2:0]       COIN2    = 3'b010;
    localparam logic [2:0]       COIN5    = 3'b100;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] shortfall_q, shortfall_d;
    logic [CNT_W-1:0] coins_paid_q, coins_paid_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [CNT_W-1:0] cnt2_q, cnt2_d;
    logic [CNT_W-1:0] cnt5_q, cnt5_d;
    logic [2:0]       coin_out_q, coin_out_d;
    logic             coin_valid_q, coin_valid_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             refill_ok;
    logic [CNT_W-1:0] denom;

    assign refill_ok = refill_valid &&
                       ((refill_sel == COIN1) || (refill_sel == COIN2) || (refill_sel == COIN5));

    // Value in zl of the coin currently offered to the hopper.
    assign denom = coin_out_q[2] ? FIVE : (coin_out_q[1] ? TWO : ONE);

    // State and datapath registers; reset restores the factory inventory and drops any pending coin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            shortfall_q  <= '0;
            coins_paid_q <= '0;
            cnt1_q       <= CNT_W'(INIT_CNT1);
            cnt2_q       <= CNT_W'(INIT_CNT2);
            cnt5_q       <= CNT_W'(INIT_CNT5);
            coin_out_q   <= 3'b000;
            coin_valid_q <= 1'b0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            shortfall_q  <= shortfall_d;
            coins_paid_q <= coins_paid_d;
            cnt1_q       <= cnt1_d;
            cnt2_q       <= cnt2_d;
            cnt5_q       <= cnt5_d;
            coin_out_q   <= coin_out_d;
            coin_valid_q <= coin_valid_d;
            gap_q        <= gap_d;
        end
    end

    // Next-state: greedy coin selection, hopper handshake, inter-coin gap and idle-time refills.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        shortfall_d  = shortfall_q;
        coins_paid_d = coins_paid_q;
        cnt1_d       = cnt1_q;
        cnt2_d       = cnt2_q;
        cnt5_d       = cnt5_q;
        coin_out_d   = coin_out_q;
        coin_valid_d = coin_valid_q;
        gap_d        = gap_q;

        case (state_q)
            S_IDLE: begin
                // Refill and start may coincide; SELECT then sees the refilled count.
                if (refill_ok) begin
                    if (refill_sel[0] && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + ONE;
                    if (refill_sel[1] && (cnt2_q != CNT_MAX)) cnt2_d = cnt2_q + ONE;
                    if (refill_sel[2] && (cnt5_q != CNT_MAX)) cnt5_d = cnt5_q + ONE;
                end
                if (start) begin
                    remaining_d  = change_amount;
                    coins_paid_d = '0;
                    shortfall_d  = '0;
                    state_d      = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining_q == '0) begin
                    shortfall_d = '0;
                    state_d     = S_DONE;
                end else if ((remaining_q >= FIVE) && (cnt5_q != '0)) begin
                    coin_out_d   = COIN5;
                    coin_valid_d = 1'b1;
                    state_d      = S_ISSUE;
                end else if ((remaining_q >= TWO) && (cnt2_q != '0)) begin
                    coin_out_d   = COIN2;
                    coin_valid_d = 1'b1;
                    state_d      = S_ISSUE;
                end else if (cnt1_q != '0) begin
                    // remaining is non-zero here, so it is at least 1.
                    coin_out_d   = COIN1;
                    coin_valid_d = 1'b1;
                    state_d      = S_ISSUE;
                end else begin
                    shortfall_d = remaining_q;
                    state_d     = S_FAIL;
                end
            end
            S_ISSUE: begin
                if (coin_ack) begin
                    // Selection guaranteed denom <= remaining and a non-empty counter.
                    remaining_d = remaining_q - denom;
                    if (coin_out_q[2])      cnt5_d = cnt5_q - ONE;
                    else if (coin_out_q[1]) cnt2_d = cnt2_q - ONE;
                    else                    cnt1_d = cnt1_q - ONE;
                    if (coins_paid_q != CNT_MAX) coins_paid_d = coins_paid_q + ONE;
                    coin_valid_d = 1'b0;
                    coin_out_d   = 3'b000;
                    if (GAP_CYCLES > 0) begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_SELECT;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_SELECT;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign coin_out   = coin_out_q;
    assign coin_valid = coin_valid_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE) || (state_q == S_FAIL);
    assign error      = (state_q == S_FAIL);
    assign shortfall  = shortfall_q;
    assign coins_paid = coins_paid_q;
    assign cnt1       = cnt1_q;
    assign cnt2       = cnt2_q;
    assign cnt5       = cnt5_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
`timescale 1ns/1ps
// Bench for coin_change_dispenser: directed scenarios plus randomized payouts against a greedy change model.
// Latency: checks first coin and zero-amount done timing relative to start.
// Backpressure: models a hopper with configurable ack delay, including long stalls.
module tb_coin_change_dispenser;

    localparam int CNT_W = 8;
    localparam int INIT  = 10;
    localparam int SAT   = 255;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] change_amount = '0;
    logic [2:0]       coin_out;
    logic             coin_valid;
    logic             coin_ack = 1'b0;
    logic             refill_valid = 1'b0;
    logic [2:0]       refill_sel = 3'b000;
    logic             busy, done, error;
    logic [CNT_W-1:0] shortfall, coins_paid, cnt1, cnt2, cnt5;

    coin_change_dispenser dut (
        .clk(clk), .reset(reset), .start(start), .change_amount(change_amount),
        .coin_out(coin_out), .coin_valid(coin_valid), .coin_ack(coin_ack),
        .refill_valid(refill_valid), .refill_sel(refill_sel),
        .busy(busy), .done(done), .error(error), .shortfall(shortfall),
        .coins_paid(coins_paid), .cnt1(cnt1), .cnt2(cnt2), .cnt5(cnt5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference inventory and expected payout.
    int         m1, m2, m5;
    int         exp_short;
    logic [2:0] exp_q[$];

    // Observed payout.
    logic [2:0] got_q[$];
    bit         seen_done, seen_err, any_valid;
    int         done_cyc, first_vld_cyc, stable_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Greedy change: largest coin that fits and is in stock, until paid or stuck.
    task automatic model_pay(input int amt);
        int rem;
        rem = amt;
        exp_q.delete();
        while (rem > 0) begin
            if (rem >= 5 && m5 > 0)      begin exp_q.push_back(3'b100); rem -= 5; m5--; end
            else if (rem >= 2 && m2 > 0) begin exp_q.push_back(3'b010); rem -= 2; m2--; end
            else if (m1 > 0)             begin exp_q.push_back(3'b001); rem -= 1; m1--; end
            else break;
        end
        exp_short = rem;
    endtask

    task automatic model_refill(input logic [2:0] sel);
        if (sel == 3'b001 && m1 < SAT) m1++;
        if (sel == 3'b010 && m2 < SAT) m2++;
        if (sel == 3'b100 && m5 < SAT) m5++;
    endtask

    function automatic bit coins_match();
        if (got_q.size() != exp_q.size()) return 1'b0;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string qstr(input logic [2:0] q[$]);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%b ", q[i])};
        return s;
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; coin_ack = 1'b0; refill_valid = 1'b0;
        refill_sel = 3'b000; change_amount = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        m1 = INIT; m2 = INIT; m5 = INIT;
    endtask

    task automatic do_refill(input logic [2:0] sel);
        refill_valid = 1'b1; refill_sel = sel;
        tick();
        refill_valid = 1'b0; refill_sel = 3'b000;
        model_refill(sel);
    endtask

    // Starts a payout and plays the hopper. poke pulses start/refill during each stall;
    // rsel is a refill presented in the same cycle as start.
    task automatic pay(input int amt, input int ack_lat, input bit poke, input logic [2:0] rsel);
        int         cyc;
        logic [2:0] c;
        logic [CNT_W-1:0] s1, s2, s5, sp;
        cyc = 0;
        got_q.delete();
        seen_done = 0; seen_err = 0; any_valid = 0;
        done_cyc = -1; first_vld_cyc = -1; stable_err = 0;
        start = 1'b1; change_amount = CNT_W'(amt);
        if (rsel != 3'b000) begin refill_valid = 1'b1; refill_sel = rsel; end
        tick();
        start = 1'b0; refill_valid = 1'b0; refill_sel = 3'b000;
        while (!seen_done && cyc < 3000) begin
            if (done === 1'b1) begin
                seen_done = 1; seen_err = error; done_cyc = cyc;
            end else if (coin_valid === 1'b1) begin
                any_valid = 1;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                c = coin_out; s1 = cnt1; s2 = cnt2; s5 = cnt5; sp = coins_paid;
                for (int i = 0; i < ack_lat; i++) begin
                    if (poke && i == 0) begin
                        start = 1'b1; change_amount = CNT_W'(50);
                        refill_valid = 1'b1; refill_sel = 3'b001;
                    end
                    tick(); cyc++;
                    start = 1'b0; refill_valid = 1'b0; refill_sel = 3'b000;
                    if (coin_valid !== 1'b1 || coin_out !== c || cnt1 !== s1 || cnt2 !== s2 ||
                        cnt5 !== s5 || coins_paid !== sp) stable_err++;
                end
                coin_ack = 1'b1;
                tick(); cyc++;
                coin_ack = 1'b0;
                got_q.push_back(c);
                if (coin_valid !== 1'b0) stable_err++;
            end else begin
                tick(); cyc++;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (coin_valid !== 1'b0) $display("FAIL reset coin_valid: got %b expected 0", coin_valid); else n_pass++;
        n_checks++; if (coin_out !== 3'b000) $display("FAIL reset coin_out: got %b expected 000", coin_out); else n_pass++;
        n_checks++; if ({busy, done, error} !== 3'b000) $display("FAIL reset busy/done/error: got %b expected 000", {busy, done, error}); else n_pass++;
        n_checks++; if (shortfall !== '0 || coins_paid !== '0) $display("FAIL reset shortfall/coins_paid: got %0d/%0d expected 0/0", shortfall, coins_paid); else n_pass++;
        n_checks++; if (cnt1 !== CNT_W'(INIT) || cnt2 !== CNT_W'(INIT) || cnt5 !== CNT_W'(INIT))
            $display("FAIL reset inventory: got %0d/%0d/%0d expected %0d each", cnt1, cnt2, cnt5, INIT); else n_pass++;
    endtask

    task automatic test_basic();
        model_pay(8);
        pay(8, 1, 0, 3'b000);
        n_checks++; if (seen_done !== 1'b1) $display("FAIL basic done: got %b expected 1", seen_done); else n_pass++;
        n_checks++; if (coins_match() !== 1'b1) $display("FAIL basic coins: got %s expected %s", qstr(got_q), qstr(exp_q)); else n_pass++;
        n_checks++; if (first_vld_cyc !== 1) $display("FAIL basic first_valid_latency: got %0d expected 1", first_vld_cyc); else n_pass++;
        n_checks++; if (seen_err !== 1'b0) $display("FAIL basic error: got %b expected 0", seen_err); else n_pass++;
        n_checks++; if (coins_paid !== CNT_W'(3)) $display("FAIL basic coins_paid: got %0d expected 3", coins_paid); else n_pass++;
        n_checks++; if (cnt5 !== CNT_W'(9) || cnt2 !== CNT_W'(9) || cnt1 !== CNT_W'(9))
            $display("FAIL basic inventory: got %0d/%0d/%0d expected 9/9/9", cnt5, cnt2, cnt1); else n_pass++;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic done_pulse: got done=%b busy=%b expected 0/0", done, busy); else n_pass++;
    endtask

    task automatic test_zero();
        model_pay(0);
        pay(0, 1, 0, 3'b000);
        n_checks++; if (done_cyc !== 1) $display("FAIL zero done_latency: got %0d expected 1", done_cyc); else n_pass++;
        n_checks++; if (any_valid !== 1'b0) $display("FAIL zero coin_valid_seen: got %b expected 0", any_valid); else n_pass++;
        n_checks++; if (coins_paid !== '0 || seen_err !== 1'b0) $display("FAIL zero coins_paid/error: got %0d/%b expected 0/0", coins_paid, seen_err); else n_pass++;
    endtask

    task automatic test_shortfall();
        while (m1 > 0) begin
            model_pay(1);
            pay(1, 0, 0, 3'b000);
            n_checks++; if (coins_match() !== 1'b1) $display("FAIL drain coins: got %s expected %s", qstr(got_q), qstr(exp_q)); else n_pass++;
        end
        model_pay(3);
        pay(3, 1, 0, 3'b000);
        n_checks++; if (coins_match() !== 1'b1) $display("FAIL short coins: got %s expected %s", qstr(got_q), qstr(exp_q)); else n_pass++;
        n_checks++; if (seen_done !== 1'b1 || seen_err !== 1'b1) $display("FAIL short done/error: got %b/%b expected 1/1", seen_done, seen_err); else n_pass++;
        n_checks++; if (shortfall !== CNT_W'(1)) $display("FAIL short shortfall: got %0d expected 1", shortfall); else n_pass++;
        n_checks++; if (cnt2 !== CNT_W'(m2) || cnt1 !== '0) $display("FAIL short inventory: got cnt2=%0d cnt1=%0d expected %0d/0", cnt2, cnt1, m2); else n_pass++;
        // Refill in the start cycle makes the 1 zl coin available to this payout.
        model_refill(3'b001);
        model_pay(1);
        pay(1, 0, 0, 3'b001);
        n_checks++; if (coins_match() !== 1'b1 || seen_err !== 1'b0)
            $display("FAIL start_refill coins: got %s err=%b expected %s err=0", qstr(got_q), seen_err, qstr(exp_q)); else n_pass++;
        n_checks++; if (shortfall !== '0 || cnt1 !== '0) $display("FAIL start_refill shortfall/cnt1: got %0d/%0d expected 0/0", shortfall, cnt1); else n_pass++;
    endtask

    task automatic test_stall();
        model_pay(7);
        pay(7, 20, 0, 3'b000);
        n_checks++; if (stable_err !== 0) $display("FAIL stall stability: got %0d unstable cycles expected 0", stable_err); else n_pass++;
        n_checks++; if (coins_match() !== 1'b1) $display("FAIL stall coins: got %s expected %s", qstr(got_q), qstr(exp_q)); else n_pass++;
        n_checks++; if (cnt5 !== CNT_W'(m5) || cnt2 !== CNT_W'(m2)) $display("FAIL stall inventory: got %0d/%0d expected %0d/%0d", cnt5, cnt2, m5, m2); else n_pass++;
    endtask

    task automatic test_refill();
        bit busy_seen;
        do_reset();
        repeat (3) do_refill(3'b001);
        do_refill(3'b011);
        n_checks++; if (cnt1 !== CNT_W'(INIT + 3) || cnt2 !== CNT_W'(INIT))
            $display("FAIL refill idle: got cnt1=%0d cnt2=%0d expected %0d/%0d", cnt1, cnt2, INIT + 3, INIT); else n_pass++;
        model_pay(6);
        pay(6, 4, 1, 3'b000);
        n_checks++; if (coins_match() !== 1'b1) $display("FAIL refill busy_coins: got %s expected %s", qstr(got_q), qstr(exp_q)); else n_pass++;
        n_checks++; if (cnt1 !== CNT_W'(m1)) $display("FAIL refill busy_ignored: got cnt1=%0d expected %0d", cnt1, m1); else n_pass++;
        busy_seen = 0;
        repeat (3) begin tick(); if (busy !== 1'b0) busy_seen = 1; end
        n_checks++; if (busy_seen !== 1'b0) $display("FAIL refill start_ignored: got busy after payout expected idle"); else n_pass++;
    endtask

    task automatic test_refill_sat();
        repeat (SAT - INIT + 5) do_refill(3'b100);
        n_checks++; if (cnt5 !== CNT_W'(SAT)) $display("FAIL refill_sat cnt5: got %0d expected %0d", cnt5, SAT); else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] sels[6] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b000, 3'b111};
        int amt, lat, k;
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++) do_refill(sels[$urandom_range(0, 5)]);
            amt = $urandom_range(0, 25);
            lat = $urandom_range(0, 3);
            model_pay(amt);
            pay(amt, lat, 0, 3'b000);
            n_checks++; if (seen_done !== 1'b1) $display("FAIL rand%0d done: got %b expected 1", it, seen_done); else n_pass++;
            n_checks++; if (coins_match() !== 1'b1) $display("FAIL rand%0d coins amt=%0d: got %s expected %s", it, amt, qstr(got_q), qstr(exp_q)); else n_pass++;
            n_checks++; if (seen_err !== (exp_short != 0)) $display("FAIL rand%0d error: got %b expected %b", it, seen_err, exp_short != 0); else n_pass++;
            n_checks++; if (shortfall !== CNT_W'(exp_short)) $display("FAIL rand%0d shortfall: got %0d expected %0d", it, shortfall, exp_short); else n_pass++;
            n_checks++; if (coins_paid !== CNT_W'(exp_q.size())) $display("FAIL rand%0d coins_paid: got %0d expected %0d", it, coins_paid, exp_q.size()); else n_pass++;
            n_checks++; if (cnt1 !== CNT_W'(m1) || cnt2 !== CNT_W'(m2) || cnt5 !== CNT_W'(m5))
                $display("FAIL rand%0d inventory: got %0d/%0d/%0d expected %0d/%0d/%0d", it, cnt1, cnt2, cnt5, m1, m2, m5); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start = 1'b1; change_amount = CNT_W'(5);
        tick();
        start = 1'b0;
        cyc = 0;
        while (coin_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        n_checks++; if (coin_valid !== 1'b1) $display("FAIL reset_mid coin_valid_reached: got %b expected 1", coin_valid); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (coin_valid !== 1'b0 || coin_out !== 3'b000 || busy !== 1'b0)
            $display("FAIL reset_mid immediate: got valid=%b out=%b busy=%b expected 0/000/0", coin_valid, coin_out, busy); else n_pass++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        m1 = INIT; m2 = INIT; m5 = INIT;
        n_checks++; if (cnt5 !== CNT_W'(INIT) || coins_paid !== '0 || busy !== 1'b0)
            $display("FAIL reset_mid after: got cnt5=%0d paid=%0d busy=%b expected %0d/0/0", cnt5, coins_paid, busy, INIT); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_shortfall();
        test_stall();
        test_refill();
        test_refill_sat();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
